// File: rtl/done_tick_timer.sv
// Programmable interval timer: emits one-cycle 'done' strobes every period*PRESCALE clocks,
// either a fixed number of times or free-running. Optional pause input under DONE_TIMER_PAUSE_EN.
module done_tick_timer #(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
`ifdef DONE_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [CNT_W-1:0] period,
  input  logic [15:0]      count,
  output logic             done,
  output logic             busy,
  output logic [15:0]      ticks
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ONE = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [15:0]      count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [15:0]      ticks_q, ticks_d;
  logic             done_q, done_d;
  logic             pause_now;

`ifdef DONE_TIMER_PAUSE_EN
  assign pause_now = pause;
`else
  assign pause_now = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      count_q  <= '0;
      pre_q    <= '0;
      step_q   <= '0;
      ticks_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      step_q   <= step_d;
      ticks_q  <= ticks_d;
      done_q   <= done_d;
    end
  end

  // A zero period behaves like a period of one, so the reload value is period-1 floored at 0.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    count_d  = count_q;
    pre_d    = pre_q;
    step_d   = step_q;
    ticks_d  = ticks_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          period_d = period;
          count_d  = count;
          ticks_d  = '0;
          pre_d    = '0;
          step_d   = (period == '0) ? '0 : period - CNT_ONE;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause_now) begin
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
            if (step_q == '0) begin
              step_d  = (period_q == '0) ? '0 : period_q - CNT_ONE;
              done_d  = 1'b1;
              ticks_d = ticks_q + 16'd1;
              if (count_q != 16'd0 && (ticks_q + 16'd1) == count_q)
                state_d = IDLE;
            end else begin
              step_d = step_q - CNT_ONE;
            end
          end else begin
            pre_d = pre_q + PRE_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done  = done_q;
  assign busy  = (state_q == RUN);
  assign ticks = ticks_q;

endmodule
